// File: rtl/line_buf_ctrl.sv
// Two-line buffer controller for a 1-bit pixel stream feeding a 3-row window column.
// Optional FIFO misuse detection on err is enabled by defining LINE_BUF_CTRL_ERR_EN.
module line_buf_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic       pix_data,
  output logic       fifo0_wr_en,
  output logic       fifo0_wr_data,
  output logic       fifo0_rd_en,
  input  logic       fifo0_rd_data,
  input  logic       fifo0_empty,
  input  logic       fifo0_full,
  output logic       fifo1_wr_en,
  output logic       fifo1_wr_data,
  output logic       fifo1_rd_en,
  input  logic       fifo1_rd_data,
  input  logic       fifo1_empty,
  input  logic       fifo1_full,
  output logic       win_valid,
  output logic [2:0] win_col,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [2:0] {IDLE, FILL0, FILL1, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            fwd_q, fwd_d;
  logic            win_valid_q, win_valid_d;
  logic            pix_d_q, pix_d_d;
  logic [2:0]      win_hold_q, win_hold_d;

  logic accept, line_end, frame_end, drain;

  assign drain     = (state_q == DRAIN);
  assign accept    = pix_valid && (state_q inside {FILL0, FILL1, RUN});
  assign line_end  = accept && (col_q == CW'(IMG_WIDTH - 1));
  assign frame_end = line_end && (row_q == RW'(IMG_HEIGHT - 1));

  // FIFO strobes follow the accepted pixel in the same cycle; data is gated so
  // that idle/reset cycles present zeros on the write buses.
  assign fifo0_wr_en   = accept;
  assign fifo0_wr_data = accept & pix_data;
  assign fifo0_rd_en   = (accept && (state_q != FILL0)) || (drain && !fifo0_empty);
  assign fifo1_rd_en   = (accept && (state_q == RUN))   || (drain && !fifo1_empty);
  assign fifo1_wr_en   = fwd_q;
  assign fifo1_wr_data = fwd_q & fifo0_rd_data;

  assign win_valid = win_valid_q;
  assign win_col   = win_valid_q ? {pix_d_q, fifo0_rd_data, fifo1_rd_data} : win_hold_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    // Only line-forwarding reads refill fifo1; drain reads just discard data.
    fwd_d       = accept && (state_q != FILL0);
    win_valid_d = accept && (state_q == RUN);
    pix_d_d     = accept ? pix_data : pix_d_q;
    win_hold_d  = win_col;

    if (accept) begin
      if (line_end) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FILL0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      FILL0: begin
        if (frame_start)   state_d = DRAIN;
        else if (line_end) state_d = FILL1;
      end
      FILL1: begin
        if (frame_start)   state_d = DRAIN;
        else if (line_end) state_d = RUN;
      end
      RUN: begin
        if (frame_start || frame_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo0_empty && fifo1_empty && !fwd_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      fwd_q       <= 1'b0;
      win_valid_q <= 1'b0;
      pix_d_q     <= 1'b0;
      win_hold_q  <= 3'b000;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fwd_q       <= fwd_d;
      win_valid_q <= win_valid_d;
      pix_d_q     <= pix_d_d;
      win_hold_q  <= win_hold_d;
    end
  end

`ifdef LINE_BUF_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (fifo0_rd_en & fifo0_empty) | (fifo1_rd_en & fifo1_empty)
          | (fifo0_wr_en & fifo0_full)  | (fifo1_wr_en & fifo1_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  // Full flags only matter to the misuse checker.
  logic unused_full;
  assign unused_full = fifo0_full ^ fifo1_full;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl at 4x4 with behavioral 1-bit FIFOs (1-cycle read latency).
// Expected err behaviour follows LINE_BUF_CTRL_ERR_EN.
module tb_line_buf_ctrl;
  localparam int W = 4;
  localparam int H = 4;
`ifdef LINE_BUF_CTRL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0, pix_valid = 1'b0, pix_data = 1'b0;
  logic fifo0_wr_en, fifo0_wr_data, fifo0_rd_en, fifo0_rd_data, fifo0_empty, fifo0_full;
  logic fifo1_wr_en, fifo1_wr_data, fifo1_rd_en, fifo1_rd_data, fifo1_empty, fifo1_full;
  logic win_valid, busy, err;
  logic [2:0] win_col;
  logic force_full0 = 1'b0;

  always #5 clk = ~clk;

  line_buf_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .fifo0_wr_en(fifo0_wr_en), .fifo0_wr_data(fifo0_wr_data), .fifo0_rd_en(fifo0_rd_en),
    .fifo0_rd_data(fifo0_rd_data), .fifo0_empty(fifo0_empty), .fifo0_full(fifo0_full),
    .fifo1_wr_en(fifo1_wr_en), .fifo1_wr_data(fifo1_wr_data), .fifo1_rd_en(fifo1_rd_en),
    .fifo1_rd_data(fifo1_rd_data), .fifo1_empty(fifo1_empty), .fifo1_full(fifo1_full),
    .win_valid(win_valid), .win_col(win_col), .busy(busy), .err(err)
  );

  // Behavioral FIFOs, reset by the same rst_n.
  logic mem0 [0:15];
  logic mem1 [0:15];
  int   wp0, rp0, wp1, rp1;
  logic rd0_q, rd1_q;

  always @(posedge clk) begin
    if (rst_n && fifo0_wr_en) mem0[wp0 % 16] <= fifo0_wr_data;
    if (rst_n && fifo1_wr_en) mem1[wp1 % 16] <= fifo1_wr_data;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp0 <= 0; rp0 <= 0; rd0_q <= 1'b0;
      wp1 <= 0; rp1 <= 0; rd1_q <= 1'b0;
    end else begin
      if (fifo0_wr_en) wp0 <= wp0 + 1;
      if (fifo1_wr_en) wp1 <= wp1 + 1;
      if (fifo0_rd_en && wp0 != rp0) begin rd0_q <= mem0[rp0 % 16]; rp0 <= rp0 + 1; end
      if (fifo1_rd_en && wp1 != rp1) begin rd1_q <= mem1[rp1 % 16]; rp1 <= rp1 + 1; end
    end
  end

  assign fifo0_rd_data = rd0_q;
  assign fifo1_rd_data = rd1_q;
  assign fifo0_empty   = (wp0 == rp0);
  assign fifo1_empty   = (wp1 == rp1);
  assign fifo0_full    = (wp0 - rp0 >= 16) || force_full0;
  assign fifo1_full    = (wp1 - rp1 >= 16);

  // Event monitor sampled on the falling edge.
  bit   clr = 1'b0;
  int   n0w, n0r, n1w, n1r, nwin;
  logic [2:0] wc [0:31];

  always @(negedge clk) begin
    if (clr) begin
      n0w <= 0; n0r <= 0; n1w <= 0; n1r <= 0; nwin <= 0;
    end else begin
      if (fifo0_wr_en) n0w <= n0w + 1;
      if (fifo0_rd_en) n0r <= n0r + 1;
      if (fifo1_wr_en) n1w <= n1w + 1;
      if (fifo1_rd_en) n1r <= n1r + 1;
      if (win_valid) begin
        if (nwin < 32) wc[nwin] <= win_col;
        nwin <= nwin + 1;
      end
    end
  end

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  logic [2:0] exp_wc [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  // frame_start pulse with a coincident valid pixel that must be ignored.
  task automatic start_frame();
    frame_start = 1'b1; pix_valid = 1'b1; pix_data = 1'b1;
    tick();
    frame_start = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
  endtask

  // Diagonal test image: row r has its single 1 at column r.
  task automatic send_pixels(input int first, input int count, input int gap);
    for (int i = first; i < first + count; i++) begin
      pix_valid = 1'b1;
      pix_data  = ((i % W) == (i / W));
      tick();
      pix_valid = 1'b0;
      pix_data  = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, (n < 200), 1);
    tick();
    tick();
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_win_count"}, nwin, 8);
    for (int k = 0; k < 8; k++) check($sformatf("%s_win_col%0d", tag, k), wc[k], exp_wc[k]);
    check({tag, "_f0_writes"}, n0w, 16);
    check({tag, "_f0_reads"},  n0r, 16);
    check({tag, "_f1_writes"}, n1w, 12);
    check({tag, "_f1_reads"},  n1r, 12);
    check({tag, "_f0_empty"},  fifo0_empty, 1);
    check({tag, "_f1_empty"},  fifo1_empty, 1);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_err"},       err, 0);
    $display("frame %s: windows=%0d f0 w/r=%0d/%0d f1 w/r=%0d/%0d", tag, nwin, n0w, n0r, n1w, n1r);
  endtask

  initial begin
    exp_wc[0] = 3'b001; exp_wc[1] = 3'b010; exp_wc[2] = 3'b100; exp_wc[3] = 3'b000;
    exp_wc[4] = 3'b000; exp_wc[5] = 3'b001; exp_wc[6] = 3'b010; exp_wc[7] = 3'b100;

    // Reset state, with a live pixel on the input that must not leak out.
    pix_valid = 1'b1; pix_data = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_col", win_col, 0);
    check("rst_wr_en", {fifo0_wr_en, fifo1_wr_en, fifo0_rd_en, fifo1_rd_en}, 0);
    check("rst_wr_data", {fifo0_wr_data, fifo1_wr_data}, 0);
    pix_valid = 1'b0; pix_data = 1'b0;
    rst_n = 1'b1;
    tick();
    clear_counts();

    // Continuous-valid frame.
    start_frame();
    check("a_busy_after_start", busy, 1);
    send_pixels(0, W * H, 0);
    wait_idle("a");
    check_frame("a");

    // Same frame, pix_valid every other cycle.
    clear_counts();
    start_frame();
    send_pixels(0, W * H, 1);
    wait_idle("b");
    check_frame("b");

    // Abort after 6 pixels (inside FILL1).
    clear_counts();
    start_frame();
    send_pixels(0, 6, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle("abort");
    check("abort_win_count", nwin, 0);
    check("abort_f0_writes", n0w, 6);
    check("abort_f0_reads", n0r, 6);
    check("abort_f1_writes", n1w, 2);
    check("abort_f1_reads", n1r, 2);
    check("abort_empty", {fifo0_empty, fifo1_empty}, 2'b11);
    check("abort_busy", busy, 0);
    $display("frame abort: f0 w/r=%0d/%0d f1 w/r=%0d/%0d", n0w, n0r, n1w, n1r);

    // Asynchronous reset while in RUN.
    clear_counts();
    start_frame();
    send_pixels(0, 2 * W + 1, 0);
    pix_valid = 1'b1; pix_data = 1'b1;
    check("run_win_valid_pre", win_valid, 1);
    check("run_win_col_pre", win_col, 3'b001);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_win_valid", win_valid, 0);
    check("arst_win_col", win_col, 0);
    check("arst_strobes", {fifo0_wr_en, fifo1_wr_en, fifo0_rd_en, fifo1_rd_en}, 0);
    check("arst_wr_data", {fifo0_wr_data, fifo1_wr_data}, 0);
    pix_valid = 1'b0; pix_data = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_counts();
    start_frame();
    send_pixels(0, W * H, 0);
    wait_idle("c");
    check_frame("c");

    // Write while full during FILL0.
    clear_counts();
    start_frame();
    force_full0 = 1'b1;
    send_pixels(0, 1, 0);
    force_full0 = 1'b0;
    check("err_set", err, EXP_ERR);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle("err");
    check("err_sticky_idle", err, EXP_ERR);
    start_frame();
    check("err_kept_on_start", err, EXP_ERR);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle("err2");
    check("err_sticky_end", err, EXP_ERR);
    $display("err test: err=%0d", err);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
